multimode_ff_reg: RTL and testbench

//  - WIDTH-bit register bank. Each bit acts as a D, T, JK or SR flip-flop, selected at run time by a mode input.
//  - Also hold, shift-left, shift-right and rotate-left modes with a serial port.
//  - Flags SR conflicts (S=R=1) with a sticky error bit and pulses a change indicator.
//  - Generalised storage primitive for the flip-flop conversion and counter/shift exercises.

---
 rtl/multimode_ff_reg.sv | 117 +++++++++++
 tb/tb_multimode_ff_reg.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multimode_ff_reg.sv
// multimode_ff_reg: WIDTH-bit bank of run-time selectable D/T/JK/SR flip-flops
// with hold/shift/rotate modes, sticky SR-conflict flag and change pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst        async active-low reset
//   sclr       sync clear of q to RESET_VAL (beats en/mode)
//   en         update enable
//   mode       000 hold,001 D,010 T,011 JK,100 SR,101 SHL,110 SHR,111 ROL
//   d, k       D/T/J/S vector, K/R vector
//   ser_in     serial input for shifts
//   err_clr    clears sr_err (a same-edge set wins)
//   q          register state
//   ser_out    last bit shifted/rotated out
//   sr_err     sticky S=R=1 flag
//   q_changed  one-cycle pulse after q changed
module multimode_ff_reg #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int unsigned      SR_CONFLICT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] k,
  input  logic             ser_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             sr_err,
  output logic             q_changed
);

  logic [WIDTH-1:0] q_nxt;
  logic             so_nxt;
  logic             err_set;
  logic [WIDTH-1:0] sin_lo;
  logic [WIDTH-1:0] sin_hi;
  logic [WIDTH-1:0] msb_lo;
  logic [WIDTH-1:0] conf;
  logic [WIDTH-1:0] sr_conf;

  // Shift operands built as full-width vectors so WIDTH=1 needs no slicing:
  // (q<<1)|ser_in and (q>>1)|ser_in<<(W-1) both collapse to ser_in there.
  always_comb begin
    sin_lo            = '0;
    sin_lo[0]         = ser_in;
    sin_hi            = '0;
    sin_hi[WIDTH-1]   = ser_in;
    msb_lo            = '0;
    msb_lo[0]         = q[WIDTH-1];
  end

  assign conf = d & k;

  always_comb begin
    unique case (SR_CONFLICT)
      1:       sr_conf = '0;
      2:       sr_conf = conf;
      default: sr_conf = q & conf;
    endcase
  end

  always_comb begin
    q_nxt   = q;
    so_nxt  = ser_out;
    err_set = 1'b0;
    if (sclr) begin
      q_nxt = RESET_VAL;
    end else if (en) begin
      unique case (mode)
        3'b000: q_nxt = q;
        3'b001: q_nxt = d;
        3'b010: q_nxt = q ^ d;
        3'b011: q_nxt = (d & ~q) | (~k & q);
        3'b100: begin
          q_nxt   = (d & ~k) | (q & ~d & ~k) | sr_conf;
          err_set = |conf;
        end
        3'b101: begin
          q_nxt  = (q << 1) | sin_lo;
          so_nxt = q[WIDTH-1];
        end
        3'b110: begin
          q_nxt  = (q >> 1) | sin_hi;
          so_nxt = q[0];
        end
        3'b111: begin
          q_nxt  = (q << 1) | msb_lo;
          so_nxt = q[WIDTH-1];
        end
        default: q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q         <= RESET_VAL;
      ser_out   <= 1'b0;
      sr_err    <= 1'b0;
      q_changed <= 1'b0;
    end else begin
      q         <= q_nxt;
      ser_out   <= so_nxt;
      q_changed <= (q_nxt != q);
      if (err_set)
        sr_err <= 1'b1;
      else if (err_clr)
        sr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multimode_ff_reg.sv
// tb_multimode_ff_reg: vector table, async-reset sequence and
// randomized run against a behavioural model.
module tb_multimode_ff_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         sclr;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic [W-1:0] k;
  logic         ser_in;
  logic         err_clr;
  logic [W-1:0] q;
  logic         ser_out;
  logic         sr_err;
  logic         q_changed;

  int total = 0;
  int passed = 0;

  multimode_ff_reg #(
    .WIDTH(W),
    .RESET_VAL(8'h00),
    .SR_CONFLICT(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sclr(sclr),
    .en(en),
    .mode(mode),
    .d(d),
    .k(k),
    .ser_in(ser_in),
    .err_clr(err_clr),
    .q(q),
    .ser_out(ser_out),
    .sr_err(sr_err),
    .q_changed(q_changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sclr;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] k;
    logic       ser_in;
    logic       err_clr;
    logic [7:0] eq;
    logic       eso;
    logic       eerr;
    logic       echg;
  } vec_t;

  vec_t vt[$];

  // reference model state
  int mq;
  int mso;
  int merr;
  int mchg;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic add(logic s, logic e, logic [2:0] m,
                     logic [7:0] dd, logic [7:0] kk, logic si,
                     logic ec, logic [7:0] eq, logic eso,
                     logic eerr, logic echg);
    vec_t v;
    v.sclr = s; v.en = e; v.mode = m; v.d = dd; v.k = kk;
    v.ser_in = si; v.err_clr = ec; v.eq = eq; v.eso = eso;
    v.eerr = eerr; v.echg = echg;
    vt.push_back(v);
  endtask

  // Model one edge from the rules, using integer arithmetic per bit.
  task automatic model_edge();
    int nq;
    int nso;
    int qb;
    int sb;
    int rb;
    nq  = mq;
    nso = mso;
    if (sclr) begin
      nq = 0;
    end else if (en) begin
      case (int'(mode))
        1: nq = int'(d);
        2: nq = mq ^ int'(d);
        3, 4: begin
          nq = 0;
          for (int i = 0; i < W; i++) begin
            qb = (mq >> i) % 2;
            sb = d[i];
            rb = k[i];
            if (mode == 3) begin
              if (sb == 1 && rb == 1) qb = 1 - qb;
              else if (sb == 1) qb = 1;
              else if (rb == 1) qb = 0;
            end else begin
              if (sb == 1 && rb == 0) qb = 1;
              else if (sb == 0 && rb == 1) qb = 0;
            end
            nq = nq + qb * (2 ** i);
          end
        end
        5: begin
          nq  = (mq * 2 + int'(ser_in)) % 256;
          nso = mq / 128;
        end
        6: begin
          nq  = mq / 2 + int'(ser_in) * 128;
          nso = mq % 2;
        end
        7: begin
          nq  = (mq * 2) % 256 + mq / 128;
          nso = mq / 128;
        end
        default: nq = mq;
      endcase
    end
    if (!sclr && en && mode == 3'b100 && (d & k) != 0) merr = 1;
    else if (err_clr) merr = 0;
    mchg = (nq != mq) ? 1 : 0;
    mq   = nq;
    mso  = nso;
  endtask

  initial begin
    rst = 1'b0; sclr = 1'b0; en = 1'b1; mode = 3'b001;
    d = 8'hFF; k = 8'h00; ser_in = 1'b0; err_clr = 1'b0;

    // reset held with clock running
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", q, 8'h00);
    chk("rst_so", ser_out, 0);
    chk("rst_err", sr_err, 0);
    chk("rst_chg", q_changed, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_q", q, 8'hFF);
    chk("rel_chg", q_changed, 1);
    @(posedge clk); #1;
    chk("rel_chg_drop", q_changed, 0);

    // s  e  mode    d      k      si ec  q      so err chg
    add(0, 1, 3'd1, 8'hA5, 8'h00, 0, 0, 8'hA5, 0, 0, 1);
    add(0, 1, 3'd2, 8'h0F, 8'h00, 0, 0, 8'hAA, 0, 0, 1);
    add(0, 1, 3'd2, 8'h0F, 8'h00, 0, 0, 8'hA5, 0, 0, 1);
    add(0, 0, 3'd2, 8'h0F, 8'h00, 0, 0, 8'hA5, 0, 0, 0);
    add(0, 1, 3'd1, 8'hF0, 8'h00, 0, 0, 8'hF0, 0, 0, 1);
    add(0, 1, 3'd3, 8'hCC, 8'hAA, 0, 0, 8'h5C, 0, 0, 1);
    add(0, 1, 3'd1, 8'h0F, 8'h00, 0, 0, 8'h0F, 0, 0, 1);
    add(0, 1, 3'd4, 8'h11, 8'h01, 0, 1, 8'h1F, 0, 1, 1);
    add(0, 1, 3'd0, 8'h00, 8'h00, 0, 1, 8'h1F, 0, 0, 0);
    add(0, 1, 3'd1, 8'h81, 8'h00, 0, 0, 8'h81, 0, 0, 1);
    add(0, 1, 3'd5, 8'h00, 8'h00, 0, 0, 8'h02, 1, 0, 1);
    add(0, 1, 3'd6, 8'h00, 8'h00, 0, 0, 8'h01, 0, 0, 1);
    add(0, 1, 3'd1, 8'h81, 8'h00, 0, 0, 8'h81, 0, 0, 1);
    add(0, 1, 3'd7, 8'h00, 8'h00, 0, 0, 8'h03, 1, 0, 1);
    add(0, 1, 3'd7, 8'h00, 8'h00, 0, 0, 8'h06, 0, 0, 1);
    add(0, 1, 3'd7, 8'h00, 8'h00, 0, 0, 8'h0C, 0, 0, 1);
    add(0, 1, 3'd7, 8'h00, 8'h00, 0, 0, 8'h18, 0, 0, 1);
    add(0, 1, 3'd7, 8'h00, 8'h00, 0, 0, 8'h30, 0, 0, 1);
    add(0, 1, 3'd7, 8'h00, 8'h00, 0, 0, 8'h60, 0, 0, 1);
    add(0, 1, 3'd7, 8'h00, 8'h00, 0, 0, 8'hC0, 0, 0, 1);
    add(0, 1, 3'd7, 8'h00, 8'h00, 0, 0, 8'h81, 1, 0, 1);
    add(0, 1, 3'd1, 8'h3C, 8'h00, 0, 0, 8'h3C, 1, 0, 1);
    add(1, 1, 3'd1, 8'hFF, 8'h00, 0, 0, 8'h00, 1, 0, 1);
    add(1, 1, 3'd1, 8'hFF, 8'h00, 0, 0, 8'h00, 1, 0, 0);
    add(0, 0, 3'd4, 8'hFF, 8'hFF, 0, 0, 8'h00, 1, 0, 0);
    add(1, 1, 3'd4, 8'h01, 8'h01, 0, 0, 8'h00, 1, 0, 0);
    add(0, 1, 3'd4, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 0);
    add(0, 1, 3'd6, 8'h00, 8'h00, 1, 0, 8'h80, 0, 0, 1);

    foreach (vt[i]) begin
      sclr = vt[i].sclr; en = vt[i].en; mode = vt[i].mode;
      d = vt[i].d; k = vt[i].k; ser_in = vt[i].ser_in;
      err_clr = vt[i].err_clr;
      @(posedge clk); #1;
      chk($sformatf("v%0d_q", i), q, vt[i].eq);
      chk($sformatf("v%0d_so", i), ser_out, vt[i].eso);
      chk($sformatf("v%0d_err", i), sr_err, vt[i].eerr);
      chk($sformatf("v%0d_chg", i), q_changed, vt[i].echg);
    end

    // async reset mid-cycle, no edge needed
    sclr = 0; en = 1; mode = 3'd4; d = 8'h3C; k = 8'h04; err_clr = 0;
    @(posedge clk); #1;
    chk("pre_arst_q", q, 8'hB8);
    chk("pre_arst_err", sr_err, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_q", q, 8'h00);
    chk("arst_err", sr_err, 0);
    chk("arst_so", ser_out, 0);
    chk("arst_chg", q_changed, 0);
    @(negedge clk);
    rst = 1'b1;
    mode = 3'd0;
    @(posedge clk); #1;
    chk("post_arst_chg", q_changed, 0);

    // randomized against model
    mq = int'(q); mso = int'(ser_out); merr = int'(sr_err); mchg = 0;
    for (int n = 0; n < 500; n++) begin
      sclr    = ($urandom_range(0, 15) == 0);
      en      = ($urandom_range(0, 7) != 0);
      mode    = 3'($urandom_range(0, 7));
      d       = 8'($urandom);
      k       = 8'($urandom);
      ser_in  = 1'($urandom);
      err_clr = ($urandom_range(0, 5) == 0);
      @(posedge clk);
      model_edge();
      #1;
      chk("rnd_q", q, mq);
      chk("rnd_so", ser_out, mso);
      chk("rnd_err", sr_err, merr);
      chk("rnd_chg", q_changed, mchg);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
